modex_frame_sequencer: RTL and testbench

Upstream controller for MODEX_Processor.
- Walks the encrypted-frame address space word by word.
- For each word: pulses the processor's active-high rst to start it, waits the processor's fixed compute time, then captures the decrypted word.
- Hands each captured word to the downstream frame writer over a valid/ready handshake.
- Replaces the bench-driven address/rst sequencing so a full frame decrypts in hardware.

---
 rtl/modex_pkg.sv | 24 ++
 rtl/modex_cycle_timer.sv | 43 ++++
 rtl/modex_frame_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_modex_frame_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/modex_pkg.sv
// Shared types and constants for the MODEX frame sequencer.
package modex_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned ARQ_W  = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KICK = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  // Bits needed to hold max_cycles-1; never less than one bit.
  function automatic int cnt_width(input int max_cycles);
    if (max_cycles <= 2) begin
      return 1;
    end else begin
      return $clog2(max_cycles);
    end
  endfunction

endpackage

// File: rtl/modex_cycle_timer.sv
// Loadable down-counter shared by the KICK and WAIT phases; zero_o is registered
// and reflects the count currently held.
module modex_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         zero_q;

  // Next count: load has priority, otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Count and zero flag registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= {W{1'b0}};
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= (count_d == {W{1'b0}});
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/modex_frame_sequencer.sv
// Walks a frame word by word through MODEX_Processor and streams results downstream.
// Defining MODEX_SEQ_CHECKSUM_EN adds checksum_o, a running sum of accepted words.
module modex_frame_sequencer
  import modex_pkg::*;
#(
  parameter int unsigned ADDR        = ADDR_W,
  parameter int unsigned ARQ         = ARQ_W,
  parameter int unsigned NUM_WORDS   = 204800,
  parameter int unsigned KICK_CYCLES = 5,
  parameter int unsigned WAIT_CYCLES = 15
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            core_rst_o,
  output logic [ADDR-1:0] core_addr_o,
  input  logic [ARQ-1:0]  core_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [ARQ-1:0]  out_data_o,
  output logic [ADDR-1:0] out_addr_o
`ifdef MODEX_SEQ_CHECKSUM_EN
  ,
  output logic [ARQ-1:0]  checksum_o
`endif
);

  localparam int CNT_W = cnt_width((KICK_CYCLES > WAIT_CYCLES) ? KICK_CYCLES : WAIT_CYCLES);
  localparam logic [CNT_W-1:0] KICK_LOAD = CNT_W'(KICK_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 32'd1);
  localparam logic [ADDR-1:0]  LAST_ADDR = ADDR'(NUM_WORDS - 32'd1);

  seq_state_t      state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            core_rst_q, core_rst_d;
  logic [ADDR-1:0] core_addr_q, core_addr_d;
  logic            out_valid_q, out_valid_d;
  logic [ARQ-1:0]  out_data_q, out_data_d;
  logic [ADDR-1:0] out_addr_q, out_addr_d;

  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_load_val_s;
  logic             tmr_en_s;
  logic             tmr_zero_s;
  logic             handshake_s;

  assign handshake_s = out_valid_q & out_ready_i;
  assign tmr_en_s    = (state_q == KICK) || (state_q == WAIT);

  modex_cycle_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_load_val_s),
    .en_i       (tmr_en_s),
    .zero_o     (tmr_zero_s)
  );

  // Next state, datapath next values and timer control.
  always_comb begin
    state_d        = state_q;
    core_addr_d    = core_addr_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_addr_d     = out_addr_q;
    tmr_load_s     = 1'b0;
    tmr_load_val_s = KICK_LOAD;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d        = KICK;
          core_addr_d    = {ADDR{1'b0}};
          tmr_load_s     = 1'b1;
          tmr_load_val_s = KICK_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      KICK: begin
        if (tmr_zero_s) begin
          state_d        = WAIT;
          tmr_load_s     = 1'b1;
          tmr_load_val_s = WAIT_LOAD;
        end else begin
          state_d = KICK;
        end
      end
      WAIT: begin
        if (tmr_zero_s) begin
          state_d     = EMIT;
          out_data_d  = core_data_i;
          out_addr_d  = core_addr_q;
          out_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      EMIT: begin
        if (handshake_s) begin
          out_valid_d = 1'b0;
          // The last address ends the frame without wrapping core_addr.
          if (core_addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            state_d        = KICK;
            core_addr_d    = core_addr_q + ADDR'(1'b1);
            tmr_load_s     = 1'b1;
            tmr_load_val_s = KICK_LOAD;
          end
        end else begin
          state_d = EMIT;
        end
      end
      DONE: begin
        state_d     = IDLE;
        core_addr_d = {ADDR{1'b0}};
      end
      default: begin
        state_d     = IDLE;
        core_addr_d = {ADDR{1'b0}};
        out_valid_d = 1'b0;
      end
    endcase
    busy_d     = (state_d == KICK) || (state_d == WAIT) || (state_d == EMIT);
    done_d     = (state_d == DONE);
    core_rst_d = (state_d == KICK);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      core_rst_q  <= 1'b0;
      core_addr_q <= {ADDR{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {ARQ{1'b0}};
      out_addr_q  <= {ADDR{1'b0}};
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      core_rst_q  <= core_rst_d;
      core_addr_q <= core_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign core_rst_o  = core_rst_q;
  assign core_addr_o = core_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = out_addr_q;

`ifdef MODEX_SEQ_CHECKSUM_EN
  logic [ARQ-1:0] checksum_q, checksum_d;

  // Sum restarts with each accepted start and accumulates every handshake.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == IDLE) && start_i) begin
      checksum_d = {ARQ{1'b0}};
    end else if (handshake_s) begin
      checksum_d = checksum_q + out_data_q;
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      checksum_q <= {ARQ{1'b0}};
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_modex_frame_sequencer.sv
// Scoreboard bench for modex_frame_sequencer with a behavioural MODEX core model.
module tb_modex_frame_sequencer;

  localparam int NW = 4;
  localparam int KC = 2;
  localparam int WC = 3;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, out_ready, start1;
  logic        ready1 = 1'b1;
  logic        busy, done, core_rst, out_valid;
  logic [17:0] core_addr, out_addr;
  logic [15:0] core_data, out_data;
  logic        busy1, done1, core_rst1, out_valid1;
  logic [17:0] core_addr1, out_addr1;
  logic [15:0] core_data1, out_data1;
`ifdef MODEX_SEQ_CHECKSUM_EN
  logic [15:0] checksum, checksum1;
`endif

  int   lowcnt = 0;
  int   lowcnt1 = 0;
  exp_t sb_q[$];
  int   hs_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done1_cnt = 0;
  int   hs1_cnt = 0;
  logic [15:0] exp_data [4] = '{16'd1, 16'd4, 16'd7, 16'd10};

  always #5 clk = ~clk;

  // Core model: result valid only after WC clocks with rst low.
  always @(posedge clk) begin
    if (core_rst) lowcnt <= 0;
    else if (lowcnt < 8) lowcnt <= lowcnt + 1;
    if (core_rst1) lowcnt1 <= 0;
    else if (lowcnt1 < 8) lowcnt1 <= lowcnt1 + 1;
  end

  assign core_data  = (!core_rst  && lowcnt  >= WC - 1) ? 16'(core_addr)  * 16'd3 + 16'd1 : 16'hFFFF;
  assign core_data1 = (!core_rst1 && lowcnt1 >= WC - 1) ? 16'(core_addr1) * 16'd3 + 16'd1 : 16'hFFFF;

  modex_frame_sequencer #(
    .NUM_WORDS(NW), .KICK_CYCLES(KC), .WAIT_CYCLES(WC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .core_rst_o(core_rst), .core_addr_o(core_addr), .core_data_i(core_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_addr_o(out_addr)
`ifdef MODEX_SEQ_CHECKSUM_EN
    , .checksum_o(checksum)
`endif
  );

  modex_frame_sequencer #(
    .NUM_WORDS(1), .KICK_CYCLES(KC), .WAIT_CYCLES(WC)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .core_rst_o(core_rst1), .core_addr_o(core_addr1), .core_data_i(core_data1),
    .out_valid_o(out_valid1), .out_ready_i(ready1), .out_data_o(out_data1),
    .out_addr_o(out_addr1)
`ifdef MODEX_SEQ_CHECKSUM_EN
    , .checksum_o(checksum1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = 18'(i);
      e.data = exp_data[i];
      sb_q.push_back(e);
    end
  endtask

  task automatic start_frame(input int n);
    push_frame(n);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("start_core_rst", 32'(core_rst), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_core_addr", 32'(core_addr), 32'd0);
`ifdef MODEX_SEQ_CHECKSUM_EN
    check("start_checksum_clear", 32'(checksum), 32'd0);
`endif
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt == target) break;
      tick(1);
    end
    check(name, 32'(done_cnt), 32'(target));
  endtask

  task automatic check_idle(input string p);
    check({p, "_busy"}, 32'(busy), 32'd0);
    check({p, "_done"}, 32'(done), 32'd0);
    check({p, "_core_rst"}, 32'(core_rst), 32'd0);
    check({p, "_out_valid"}, 32'(out_valid), 32'd0);
    check({p, "_core_addr"}, 32'(core_addr), 32'd0);
    check({p, "_out_addr"}, 32'(out_addr), 32'd0);
    check({p, "_out_data"}, 32'(out_data), 32'd0);
  endtask

  initial forever @(posedge clk) cyc++;

  // Monitor: pops the scoreboard on every handshake and checks done timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && out_ready) begin
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_data", 32'(out_data), 32'(e.data));
            check("sb_addr", 32'(out_addr), 32'(e.addr));
          end else begin
            check("sb_unexpected_hs", 32'(sb_q.size()), 32'd1);
          end
          hs_cyc.push_back(cyc);
        end
        if (done) begin
          done_cnt++;
          check("done_busy_low", 32'(busy), 32'd0);
          if (hs_cyc.size() > 0)
            check("done_delay", 32'(cyc - hs_cyc[hs_cyc.size()-1]), 32'd1);
        end
        if (out_valid1 && ready1) hs1_cnt++;
        if (done1) done1_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int base, dc, rst_hi, unstable;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; start1 = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check_idle("reset");
    check("reset_busy1", 32'(busy1), 32'd0);
`ifdef MODEX_SEQ_CHECKSUM_EN
    check("reset_checksum", 32'(checksum), 32'd0);
`endif

    // 1: single frame with out_ready held high
    base = hs_cyc.size();
    start_frame(NW);
    wait_done(1, "s1_done");
    check("s1_hs_count", 32'(hs_cyc.size() - base), 32'd4);
    if (hs_cyc.size() >= base + 4)
      for (int k = 1; k < 4; k++)
        check("s1_hs_spacing", 32'(hs_cyc[base+k] - hs_cyc[base+k-1]), 32'd6);
    check("s1_sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef MODEX_SEQ_CHECKSUM_EN
    check("s1_checksum", 32'(checksum), 32'd22);
`endif

    // 2: backpressure at word 2
    start_frame(NW);
    for (int i = 0; i < 100 && core_addr != 18'd2; i++) tick(1);
    check("s2_reach_w2", 32'(core_addr), 32'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 50 && !out_valid; i++) tick(1);
    check("s2_valid", 32'(out_valid), 32'd1);
    check("s2_data", 32'(out_data), 32'd7);
    check("s2_out_addr", 32'(out_addr), 32'd2);
    rst_hi = 0; unstable = 0;
    repeat (10) begin
      tick(1);
      if (core_rst) rst_hi++;
      if (!out_valid || out_data != 16'd7 || out_addr != 18'd2 || core_addr != 18'd2) unstable++;
    end
    check("s2_core_rst_low", 32'(rst_hi), 32'd0);
    check("s2_hold_stable", 32'(unstable), 32'd0);
    out_ready = 1'b1;
    wait_done(2, "s2_done");
    check("s2_sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef MODEX_SEQ_CHECKSUM_EN
    check("s2_checksum", 32'(checksum), 32'd22);
`endif

    // 3: start while busy is ignored
    start_frame(NW);
    for (int i = 0; i < 100 && !(core_addr == 18'd1 && !core_rst && !out_valid); i++) tick(1);
    check("s3_reach_wait_w1", 32'(core_addr), 32'd1);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    check("s3_no_restart_addr", 32'(core_addr), 32'd1);
    check("s3_busy", 32'(busy), 32'd1);
    wait_done(3, "s3_done");
    tick(20);
    check("s3_single_done", 32'(done_cnt), 32'd3);
    check("s3_idle_after", 32'(busy), 32'd0);
    check("s3_sb_empty", 32'(sb_q.size()), 32'd0);

    // 4: reset during KICK of word 2, then restart
    start_frame(2);
    for (int i = 0; i < 100 && !(core_addr == 18'd2 && core_rst); i++) tick(1);
    check("s4_reach_kick_w2", 32'(core_rst), 32'd1);
    dc = done_cnt;
    rst_n = 1'b0;
    tick(1);
    check_idle("s4_reset");
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("s4_no_done", 32'(done_cnt), 32'(dc));
    check("s4_sb_empty", 32'(sb_q.size()), 32'd0);
    start_frame(NW);
    wait_done(dc + 1, "s4_restart_done");
    check("s4_sb_empty_end", 32'(sb_q.size()), 32'd0);
`ifdef MODEX_SEQ_CHECKSUM_EN
    check("s4_checksum", 32'(checksum), 32'd22);
`endif

    // 5: NUM_WORDS = 1
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    check("s5_core_rst", 32'(core_rst1), 32'd1);
    for (int i = 0; i < 50 && !out_valid1; i++) tick(1);
    check("s5_valid", 32'(out_valid1), 32'd1);
    check("s5_data", 32'(out_data1), 32'd1);
    check("s5_addr", 32'(out_addr1), 32'd0);
    for (int i = 0; i < 50 && done1_cnt == 0; i++) tick(1);
    check("s5_done", 32'(done1_cnt), 32'd1);
    check("s5_hs_count", 32'(hs1_cnt), 32'd1);
    check("s5_core_addr", 32'(core_addr1), 32'd0);
    check("s5_busy", 32'(busy1), 32'd0);
`ifdef MODEX_SEQ_CHECKSUM_EN
    check("s5_checksum", 32'(checksum1), 32'd1);
`endif
    tick(10);
    check("s5_single_done", 32'(done1_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
